// File: rtl/fft_chk_pkg.sv
// Shared types and helpers for the streaming FFT output checker.
package fft_chk_pkg;

    localparam int CODE_W = 3;
    // Widest sample the compare helper accepts; callers sign-extend into it.
    localparam int MAX_DW = 32;

    typedef enum logic [CODE_W-1:0] {
        ERR_NONE        = 3'd0,
        ERR_REAL        = 3'd1,
        ERR_IMAG        = 3'd2,
        ERR_START       = 3'd3,
        ERR_UNEXP_START = 3'd4,
        ERR_TIMEOUT     = 3'd5,
        ERR_UNDERFLOW   = 3'd6
    } err_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLOCK,
        ST_FAIL
    } state_t;

    // |got - exp| computed one bit wider than the operands so that the
    // extreme pair (most negative vs most positive) cannot wrap.
    function automatic logic [MAX_DW:0] abs_diff(input logic signed [MAX_DW-1:0] got,
                                                 input logic signed [MAX_DW-1:0] exp_v);
        logic signed [MAX_DW:0] d;
        d = (MAX_DW+1)'(got) - (MAX_DW+1)'(exp_v);
        abs_diff = d[MAX_DW] ? $unsigned(-d) : $unsigned(d);
    endfunction

endpackage

// File: rtl/fft_chk_if.sv
// Expected-bin handshake plus the FFT output stream observed by the checker.
interface fft_chk_if #(
    parameter int DW = 20
) ();
    logic                 exp_valid;
    logic                 exp_ready;
    logic signed [DW-1:0] exp_real;
    logic signed [DW-1:0] exp_imag;
    logic signed [DW-1:0] dut_real;
    logic signed [DW-1:0] dut_imag;
    logic                 dut_start;

    modport master (
        output exp_valid, exp_real, exp_imag, dut_real, dut_imag, dut_start,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_real, exp_imag, dut_real, dut_imag, dut_start,
        output exp_ready
    );
endinterface

// File: rtl/fft_chk_fifo.sv
// Expected-bin FIFO: real/imag pair per entry, head visible without a pop
// so the current DUT sample can be compared in the cycle it is sampled.
module fft_chk_fifo #(
    parameter int DW    = 20,
    parameter int DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic signed [DW-1:0]       wr_real,
    input  logic signed [DW-1:0]       wr_imag,
    input  logic                       pop,
    output logic signed [DW-1:0]       rd_real,
    output logic signed [DW-1:0]       rd_imag,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [2*DW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;

    // Storage write; the caller only pushes when a slot is free or being freed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {wr_real, wr_imag};
        end
    end

    // Pointers and occupancy; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push && !pop)      count_reg <= count_reg + (AW+1)'(1);
            else if (pop && !push) count_reg <= count_reg - (AW+1)'(1);
        end
    end

    assign {rd_real, rd_imag} = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fft_stream_checker.sv
// Compares the FFT output stream against queued expected bins within +/-TOL
// and latches the first fault as a sticky error code.
module fft_stream_checker
    import fft_chk_pkg::*;
#(
    parameter int DW        = 20,
    parameter int NPTS      = 256,
    parameter int TOL       = 3,
    parameter int EXP_DEPTH = 1024,
    parameter int WATCHDOG  = 2000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fft_chk_if.slave                     bus,
    output logic                         err,
    output err_code_t                    err_code,
    output logic [$clog2(NPTS)-1:0]      err_index,
    output logic [15:0]                  blocks_passed,
    output logic                         in_block,
    output logic [$clog2(EXP_DEPTH):0]   exp_level
);
    localparam int IW = $clog2(NPTS);
    localparam int LW = $clog2(EXP_DEPTH) + 1;
    localparam int WW = $clog2(WATCHDOG + 1);

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [WW-1:0]   wd_reg, wd_next;
    logic            err_reg, err_next;
    err_code_t       code_reg, code_next;
    logic [IW-1:0]   eidx_reg, eidx_next;
    logic [15:0]     blocks_reg, blocks_next;

    logic [LW-1:0]        q_count;
    logic signed [DW-1:0] head_real, head_imag;
    logic                 q_empty, q_full, pop, push;
    logic                 real_bad, imag_bad;
    logic                 fail;
    err_code_t            fail_code;
    logic [IW-1:0]        fail_idx;

    logic signed [MAX_DW-1:0] got_r_ext, got_i_ext, exp_r_ext, exp_i_ext;

    fft_chk_fifo #(.DW(DW), .DEPTH(EXP_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_real (bus.exp_real),
        .wr_imag (bus.exp_imag),
        .pop     (pop),
        .rd_real (head_real),
        .rd_imag (head_imag),
        .count   (q_count)
    );

    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == LW'(EXP_DEPTH));
    // A sample consumed this cycle frees a slot, so a full queue still
    // accepts a push alongside a pop and the level holds.
    assign pop  = !q_empty && ((state_reg == ST_BLOCK) ||
                               (state_reg == ST_IDLE && bus.dut_start));
    assign bus.exp_ready = !q_full || pop;
    assign push = bus.exp_valid && bus.exp_ready;

    assign got_r_ext = MAX_DW'(bus.dut_real);
    assign got_i_ext = MAX_DW'(bus.dut_imag);
    assign exp_r_ext = MAX_DW'(head_real);
    assign exp_i_ext = MAX_DW'(head_imag);
    assign real_bad  = abs_diff(got_r_ext, exp_r_ext) > (MAX_DW+1)'(TOL);
    assign imag_bad  = abs_diff(got_i_ext, exp_i_ext) > (MAX_DW+1)'(TOL);

    // State, index, watchdog and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            wd_reg     <= WW'(WATCHDOG);
            err_reg    <= 1'b0;
            code_reg   <= ERR_NONE;
            eidx_reg   <= '0;
            blocks_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            wd_reg     <= wd_next;
            err_reg    <= err_next;
            code_reg   <= code_next;
            eidx_reg   <= eidx_next;
            blocks_reg <= blocks_next;
        end
    end

    // Next-state: framing, per-sample compare with code priority, watchdog.
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        wd_next     = wd_reg;
        err_next    = err_reg;
        code_next   = code_reg;
        eidx_next   = eidx_reg;
        blocks_next = blocks_reg;
        fail        = 1'b0;
        fail_code   = ERR_NONE;
        fail_idx    = idx_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.dut_start) begin
                    fail_idx = '0;
                    if (q_empty) begin
                        fail = 1'b1; fail_code = ERR_UNEXP_START;
                    end else if (real_bad) begin
                        fail = 1'b1; fail_code = ERR_REAL;
                    end else if (imag_bad) begin
                        fail = 1'b1; fail_code = ERR_IMAG;
                    end else begin
                        state_next = ST_BLOCK;
                        idx_next   = IW'(1);
                    end
                end
            end
            ST_BLOCK: begin
                idx_next = idx_reg + IW'(1);
                if (bus.dut_start) begin
                    fail = 1'b1; fail_code = ERR_START;
                end else if (!q_empty && real_bad) begin
                    fail = 1'b1; fail_code = ERR_REAL;
                end else if (!q_empty && imag_bad) begin
                    fail = 1'b1; fail_code = ERR_IMAG;
                end else if (q_empty) begin
                    fail = 1'b1; fail_code = ERR_UNDERFLOW;
                end else if (idx_reg == IW'(NPTS - 1)) begin
                    state_next = ST_IDLE;
                    if (blocks_reg != 16'hFFFF) blocks_next = blocks_reg + 16'd1;
                end
            end
            default: ;
        endcase

        if (state_reg != ST_FAIL) begin
            if (pop || q_empty) begin
                wd_next = WW'(WATCHDOG);
            end else if (wd_reg <= WW'(1)) begin
                wd_next = '0;
                if (!fail) begin
                    fail = 1'b1; fail_code = ERR_TIMEOUT; fail_idx = idx_reg;
                end
            end else begin
                wd_next = wd_reg - WW'(1);
            end
        end

        if (fail) begin
            state_next = ST_FAIL;
            err_next   = 1'b1;
            code_next  = fail_code;
            eidx_next  = fail_idx;
        end
    end

    assign err           = err_reg;
    assign err_code      = code_reg;
    assign err_index     = eidx_reg;
    assign blocks_passed = blocks_reg;
    assign in_block      = (state_reg == ST_BLOCK);
    assign exp_level     = q_count;

endmodule

// File: tb/tb_fft_stream_checker.sv
// Directed bench for fft_stream_checker with a queue-based reference model.
module tb_fft_stream_checker;
    import fft_chk_pkg::*;

    localparam int DW    = 20;
    localparam int NPTS  = 256;
    localparam int TOL   = 3;
    localparam int DEPTH = 1024;
    localparam int WD    = 2000;
    localparam int MAXV  = (1 << (DW - 1)) - 1;
    localparam int MINV  = -(1 << (DW - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fft_chk_if #(.DW(DW)) bus ();

    logic                        err;
    err_code_t                   err_code;
    logic [$clog2(NPTS)-1:0]     err_index;
    logic [15:0]                 blocks_passed;
    logic                        in_block;
    logic [$clog2(DEPTH):0]      exp_level;

    fft_stream_checker #(
        .DW(DW), .NPTS(NPTS), .TOL(TOL), .EXP_DEPTH(DEPTH), .WATCHDOG(WD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .err           (err),
        .err_code      (err_code),
        .err_index     (err_index),
        .blocks_passed (blocks_passed),
        .in_block      (in_block),
        .exp_level     (exp_level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, longint act, longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct { int re; int im; } bin_t;
    bin_t m_q[$];
    bit   m_active, m_failed;
    int   m_bin, m_idle, m_blocks, m_code, m_eidx;

    function automatic void model_reset();
        m_q.delete();
        m_active = 0; m_failed = 0;
        m_bin = 0; m_idle = 0; m_blocks = 0; m_code = 0; m_eidx = 0;
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic bit m_ready(bit ds);
        return (m_q.size() < DEPTH) ||
               (!m_failed && m_q.size() > 0 && (m_active || ds));
    endfunction

    // One sampled clock edge: what the checker must conclude from these inputs.
    function automatic void model_step(bit v, int er, int ei, bit ds, int dr, int di);
        int   sz;
        bit   popping, failing, br, bi, rdy;
        int   code, idx;
        bin_t nb;
        sz = m_q.size();
        popping = 0; failing = 0; br = 0; bi = 0; code = 0; idx = m_bin;
        rdy = m_ready(ds);
        if (sz > 0) begin
            br = iabs(dr - m_q[0].re) > TOL;
            bi = iabs(di - m_q[0].im) > TOL;
        end
        if (!m_failed) begin
            if (!m_active && ds) begin
                idx = 0;
                if (sz == 0) begin failing = 1; code = ERR_UNEXP_START; end
                else begin
                    popping = 1;
                    if (br)      begin failing = 1; code = ERR_REAL; end
                    else if (bi) begin failing = 1; code = ERR_IMAG; end
                    else begin m_active = 1; m_bin = 1; end
                end
            end else if (m_active) begin
                popping = (sz > 0);
                if (ds)             begin failing = 1; code = ERR_START; end
                else if (br)        begin failing = 1; code = ERR_REAL; end
                else if (bi)        begin failing = 1; code = ERR_IMAG; end
                else if (sz == 0)   begin failing = 1; code = ERR_UNDERFLOW; end
                else if (m_bin == NPTS - 1) begin
                    m_active = 0; m_bin = 0;
                    if (m_blocks < 65535) m_blocks++;
                end else m_bin++;
            end
            if (popping || sz == 0) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle >= WD && !failing) begin
                    failing = 1; code = ERR_TIMEOUT; idx = m_bin;
                end
            end
            if (failing) begin
                m_failed = 1; m_active = 0; m_code = code; m_eidx = idx;
            end
        end
        if (popping) void'(m_q.pop_front());
        if (v && rdy) begin
            nb.re = er; nb.im = ei;
            m_q.push_back(nb);
        end
    endfunction

    // Single compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("err",           err,           m_failed);
            chk("err_code",      err_code,      m_code);
            chk("err_index",     err_index,     m_eidx);
            chk("blocks_passed", blocks_passed, m_blocks);
            chk("in_block",      in_block,      m_active);
            chk("exp_level",     exp_level,     m_q.size());
            chk("exp_ready",     bus.exp_ready, m_ready(bus.dut_start));
        end
    end

    // ---------------- stimulus ----------------
    bin_t blk [DEPTH];

    function automatic int fit(int e, int off);
        int s;
        s = e + off;
        if (s > MAXV || s < MINV) s = e - off;
        return s;
    endfunction

    task automatic gen(input int n);
        for (int k = 0; k < n; k++) begin
            blk[k].re = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
            blk[k].im = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        end
    endtask

    task automatic cyc(input bit v, input int er, input int ei,
                       input bit ds, input int dr, input int di);
        bus.exp_valid = v;
        bus.exp_real  = DW'(er);
        bus.exp_imag  = DW'(ei);
        bus.dut_start = ds;
        bus.dut_real  = DW'(dr);
        bus.dut_imag  = DW'(di);
        @(posedge clk);
        model_step(v, er, ei, ds, dr, di);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int k = lo; k < hi; k++) cyc(1, blk[k].re, blk[k].im, 0, 0, 0);
    endtask

    // Clean sample within tolerance, offsets sweep -3..+3.
    task automatic stream_ok(input int k, input bit ds);
        cyc(0, 0, 0, ds, fit(blk[k].re, (k % 7) - 3), fit(blk[k].im, ((k * 3) % 7) - 3));
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, " err"},       err, 0);
        chk({tag, " err_code"},  err_code, 0);
        chk({tag, " err_index"}, err_index, 0);
        chk({tag, " blocks"},    blocks_passed, 0);
        chk({tag, " in_block"},  in_block, 0);
        chk({tag, " level"},     exp_level, 0);
        chk({tag, " ready"},     bus.exp_ready, 1);
    endtask

    initial begin
        bus.exp_valid = 0; bus.exp_real = '0; bus.exp_imag = '0;
        bus.dut_start = 0; bus.dut_real = '0; bus.dut_imag = '0;
        model_reset();
        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Clean block, extremes near the rails, offsets at +/-TOL.
        gen(NPTS);
        blk[3].re = MAXV; blk[4].im = MINV;
        push_range(0, NPTS);
        stream_ok(0, 1);
        chk("t1 in_block after bin0", in_block, 1);
        for (int k = 1; k < NPTS; k++) stream_ok(k, 0);
        chk("t1 blocks", blocks_passed, 1);
        chk("t1 err", err, 0);
        chk("t1 in_block after last", in_block, 0);
        $display("t1 clean block: blocks_passed=%0d err=%0d", blocks_passed, err);

        // Two blocks back to back, second block pushed while first streams.
        do_reset();
        gen(2 * NPTS);
        push_range(0, NPTS);
        for (int j = 0; j < NPTS; j++)
            cyc(1, blk[NPTS + j].re, blk[NPTS + j].im, j == 0,
                fit(blk[j].re, (j % 7) - 3), fit(blk[j].im, ((j * 3) % 7) - 3));
        for (int j = 0; j < NPTS; j++) stream_ok(NPTS + j, j == 0);
        chk("t2 blocks", blocks_passed, 2);
        chk("t2 level", exp_level, 0);
        $display("t2 back-to-back: blocks_passed=%0d level=%0d", blocks_passed, exp_level);

        // Bin 17 real off by +4.
        do_reset();
        gen(NPTS);
        push_range(0, NPTS);
        for (int k = 0; k < 17; k++) stream_ok(k, k == 0);
        cyc(0, 0, 0, 0, fit(blk[17].re, 4), blk[17].im);
        chk("t3 err", err, 1);
        chk("t3 code", err_code, ERR_REAL);
        chk("t3 index", err_index, 17);
        idle(); idle();
        chk("t3 blocks", blocks_passed, 0);
        $display("t3 real miss: code=%0d index=%0d", err_code, err_index);

        // Start mid-block at bin 100 (real also bad; start wins).
        do_reset();
        gen(NPTS);
        push_range(0, NPTS);
        for (int k = 0; k < 100; k++) stream_ok(k, k == 0);
        cyc(0, 0, 0, 1, fit(blk[100].re, 5), blk[100].im);
        chk("t4 code", err_code, ERR_START);
        chk("t4 index", err_index, 100);
        $display("t4 start mid-block: code=%0d index=%0d", err_code, err_index);

        // Start with an empty queue.
        do_reset();
        cyc(0, 0, 0, 1, 0, 0);
        chk("t5 code", err_code, ERR_UNEXP_START);
        chk("t5 index", err_index, 0);
        $display("t5 unexpected start: code=%0d", err_code);

        // Watchdog: 10 bins queued, no start ever.
        do_reset();
        gen(10);
        push_range(0, 10);
        for (int k = 0; k < WD; k++) idle();
        chk("t6 code", err_code, ERR_TIMEOUT);
        chk("t6 err", err, 1);
        $display("t6 watchdog: code=%0d", err_code);

        // Underflow: only 128 bins queued for a 256-bin stream.
        do_reset();
        gen(NPTS);
        push_range(0, 128);
        for (int k = 0; k < 131; k++) stream_ok(k, k == 0);
        chk("t7 code", err_code, ERR_UNDERFLOW);
        chk("t7 index", err_index, 128);
        $display("t7 underflow: code=%0d index=%0d", err_code, err_index);

        // Full queue, push+pop at full, then asynchronous reset mid-block.
        do_reset();
        gen(DEPTH);
        push_range(0, DEPTH);
        idle();
        chk("t8 ready at full", bus.exp_ready, 0);
        chk("t8 level full", exp_level, DEPTH);
        for (int k = 0; k < 6; k++)
            cyc(1, k, -k, k == 0, fit(blk[k].re, 1), fit(blk[k].im, -2));
        chk("t8 level push+pop", exp_level, DEPTH);
        chk("t8 in_block", in_block, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_vals("t8 async");
        rst_n = 1'b1;
        $display("t8 full/reset: level=%0d in_block=%0d", exp_level, in_block);

        // Extreme operands must not wrap; real and imag both bad -> REAL.
        do_reset();
        gen(8);
        blk[5].re = MAXV;
        push_range(0, 8);
        for (int k = 0; k < 5; k++) stream_ok(k, k == 0);
        cyc(0, 0, 0, 0, MINV, fit(blk[5].im, 6));
        chk("t9 code", err_code, ERR_REAL);
        chk("t9 index", err_index, 5);
        $display("t9 extremes: code=%0d index=%0d", err_code, err_index);

        // Imag alone off by -4.
        do_reset();
        gen(8);
        push_range(0, 8);
        for (int k = 0; k < 3; k++) stream_ok(k, k == 0);
        cyc(0, 0, 0, 0, blk[3].re, fit(blk[3].im, -4));
        chk("t10 code", err_code, ERR_IMAG);
        chk("t10 index", err_index, 3);
        $display("t10 imag miss: code=%0d index=%0d", err_code, err_index);

        idle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
